// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel-to-serial shifter feeding the sequence detector; define SER_PARITY_EN to append an even-parity bit to every word
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic last_data, last, accept, head;
`ifdef SER_PARITY_EN
  logic par_q, par_d;
`endif
  assign last_data = state_q == SHIFT && shift_en && cnt_q == CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
  assign last = state_q == PARITY && shift_en;
`else
  assign last = last_data;
`endif
  assign accept = load_valid && load_ready;
  assign head = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
  // state register; reset wins over everything, including a pending load
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  // next state: shift on enabled edges, finish on the final bit, and let an accepted word override so reloads are gapless
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = last;
`ifdef SER_PARITY_EN
    par_d   = par_q;
    if (last_data) state_d = PARITY;
`endif
    if (state_q == SHIFT && shift_en) begin
      sreg_d = LSB_FIRST ? sreg_q >> 1 : sreg_q << 1;
      cnt_d  = cnt_q + CW'(1);
    end
    if (last) state_d = IDLE;
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = load_data;
      cnt_d   = '0;
`ifdef SER_PARITY_EN
      par_d   = ^load_data;
`endif
    end
  end
  // outputs: the serial bit is only presented on enabled cycles so the detector never sees a stale repeat
  always_comb begin
    busy         = state_q != IDLE;
    load_ready   = state_q == IDLE || last;
    serial_valid = busy && shift_en;
`ifdef SER_PARITY_EN
    serial_out   = serial_valid && (state_q == PARITY ? par_q : head);
`else
    serial_out   = serial_valid && head;
`endif
    done         = done_q;
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed bench for bit_serializer (MSB-first and LSB-first instances side by side); honours SER_PARITY_EN
module tb_bit_serializer;
`ifdef SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic load_valid = 1'b1;
  logic shift_en = 1'b1;
  logic [7:0] load_data = 8'hFF;
  logic lr0, so0, sv0, b0, d0, lr1, so1, sv1, b1, d1;
  logic [4:0] o0, o1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  assign o0 = {lr0, sv0, so0, b0, d0};
  assign o1 = {lr1, sv1, so1, b1, d1};
  bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .n_rst(n_rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(lr0), .shift_en(shift_en), .serial_out(so0),
    .serial_valid(sv0), .busy(b0), .done(d0)
  );
  bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .n_rst(n_rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(lr1), .shift_en(shift_en), .serial_out(so1),
    .serial_valid(sv1), .busy(b1), .done(d1)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic bit_of(input logic [7:0] w, input int i, input bit lsb);
    return i >= 8 ? ^w : (lsb ? w[i] : w[7-i]);
  endfunction
  task automatic test_reset();
    cyc();
    cyc();
    checks++;
    if (o0 !== 5'b10000) begin errors++; $display("FAIL reset_u0: got %b want 10000 {ready,valid,out,busy,done}", o0); end
    checks++;
    if (o1 !== 5'b10000) begin errors++; $display("FAIL reset_u1: got %b want 10000", o1); end
    n_rst = 1'b1;
    load_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++;
      if (o0 !== 5'b10000) begin errors++; $display("FAIL idle_after_reset cyc%0d: got %b want 10000", k, o0); end
    end
  endtask
  task automatic run_stream(input string name, input logic [7:0] wa, input logic [7:0] wb, input int nw, input bit pace);
    logic [7:0] w;
    logic [4:0] e0, e1;
    bit en, pl;
    int i, c;
    load_data = wa;
    load_valid = 1'b1;
    shift_en = 1'b1;
    #1;
    checks++;
    if (o0 !== 5'b10000) begin errors++; $display("FAIL %s accept: got %b want 10000", name, o0); end
    cyc();
    pl = 1'b0;
    c = 0;
    for (int k = 0; k < nw; k++) begin
      w = k == 0 ? wa : wb;
      load_valid = k + 1 < nw;
      load_data = wb;
      i = 0;
      while (i < NB) begin
        en = pace ? (c % 2) == 1 : 1'b1;
        shift_en = en;
        #1;
        e0 = {en && i == NB - 1, en, en & bit_of(w, i, 1'b0), 1'b1, pl};
        e1 = {en && i == NB - 1, en, en & bit_of(w, i, 1'b1), 1'b1, pl};
        checks++;
        if (o0 !== e0) begin errors++; $display("FAIL %s msb word%0d bit%0d cyc%0d: got %b want %b", name, k, i, c, o0, e0); end
        checks++;
        if (o1 !== e1) begin errors++; $display("FAIL %s lsb word%0d bit%0d cyc%0d: got %b want %b", name, k, i, c, o1, e1); end
        pl = en && i == NB - 1;
        if (en) i++;
        c++;
        cyc();
      end
    end
    load_valid = 1'b0;
    #1;
    checks++;
    if (o0 !== 5'b10001) begin errors++; $display("FAIL %s done_pulse: got %b want 10001", name, o0); end
    cyc();
    checks++;
    if (o0 !== 5'b10000) begin errors++; $display("FAIL %s back_idle: got %b want 10000", name, o0); end
  endtask
  task automatic test_single();
    run_stream("single", 8'b11011011, 8'h00, 1, 1'b0);
  endtask
  task automatic test_back_to_back();
    run_stream("b2b", 8'hDB, 8'h5A, 2, 1'b0);
  endtask
  task automatic test_pacing();
    run_stream("pacing", 8'hA5, 8'h00, 1, 1'b1);
  endtask
  task automatic test_abort();
    load_data = 8'hFF;
    load_valid = 1'b1;
    shift_en = 1'b1;
    cyc();
    load_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    checks++;
    if (o0 !== 5'b01110) begin errors++; $display("FAIL abort_mid: got %b want 01110", o0); end
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    #1;
    checks++;
    if (o0 !== 5'b10000) begin errors++; $display("FAIL abort_u0: got %b want 10000", o0); end
    checks++;
    if (o1 !== 5'b10000) begin errors++; $display("FAIL abort_u1: got %b want 10000", o1); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (o0 !== 5'b10000) begin errors++; $display("FAIL abort_no_done cyc%0d: got %b want 10000", k, o0); end
    end
    run_stream("after_abort", 8'h0F, 8'h00, 1, 1'b0);
  endtask
  task automatic test_parity();
    run_stream("parity_db", 8'b11011011, 8'h00, 1, 1'b0);
    run_stream("parity_d0", 8'b11010000, 8'h00, 1, 1'b0);
    run_stream("parity_b2b", 8'b11010000, 8'b11011011, 2, 1'b0);
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_pacing();
    test_abort();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage directly upstream of the Mealy sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled clock on serial_out, which drives the detector's i input.
- Supports gapless back-to-back words, so a multi-word bit pattern reaches the detector as one continuous stream.

Parameters:
- WIDTH, 8, data bits per word (legal range 2..32).
- LSB_FIRST, 0, 0 = MSB shifted out first; 1 = LSB first.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- n_rst  input  1  synchronous active-low reset, sampled on rising edge of clk.
- load_data  input  WIDTH  word to serialize.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  serializer accepts a word this cycle.
- shift_en  input  1  pacing enable; the current bit is consumed only on edges where shift_en=1.
- serial_out  output  1  current serial bit; 0 whenever serial_valid=0.
- serial_valid  output  1  serial_out holds a valid bit this cycle.
- busy  output  1  word in flight (state != IDLE).
- done  output  1  one-cycle pulse the cycle after the last bit of a word is consumed.

Behaviour:
- Reset: on a clk edge with n_rst=0, state=IDLE, shift register=0, bit counter=0, done=0.
  - Resulting outputs: load_ready=1, serial_valid=0, serial_out=0, busy=0.
  - Reset takes priority over every other input, including load_valid.
- States: IDLE, SHIFT, plus PARITY when the optional feature is enabled.
- IDLE:
  - load_ready=1.
  - load_valid=1 at an edge: capture load_data into the shift register, counter=0, go to SHIFT.
- SHIFT:
  - serial_valid = shift_en.
  - serial_out = sreg[WIDTH-1] (LSB_FIRST=0) or sreg[0] (LSB_FIRST=1), gated to 0 when shift_en=0.
  - Edge with shift_en=1: shift the register by one (zero fill) and increment the counter.
  - Edge with shift_en=0: register and counter hold; load_valid is ignored.
- Last bit: counter==WIDTH-1 with shift_en=1.
  - load_ready=1 in this cycle (combinational).
  - If load_valid=1 at that edge: the new word loads, counter=0, state stays SHIFT. The stream continues with no idle cycle.
  - Otherwise the state goes to IDLE.
  - In both cases done is asserted for exactly the next cycle.
- load_ready=0 in every other SHIFT cycle; load_valid and load_data are don't-care there and nothing is captured.
- First-bit latency: the first bit is valid in the cycle after acceptance.
  - A word of WIDTH bits occupies exactly WIDTH enabled cycles.
- Counter width: $clog2(WIDTH+1); it never exceeds WIDTH.
- Reset mid-word: the word is aborted, no done pulse is issued, and the block is in IDLE after that edge.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - The last data bit transitions to PARITY instead of IDLE/reload.
  - PARITY emits one extra bit: even parity, the XOR of all WIDTH bits of the captured word, stored at load time.
  - The parity bit obeys shift_en exactly like data bits.
  - The load_ready / back-to-back reload window and the done pulse move to the PARITY cycle. A word therefore occupies WIDTH+1 enabled cycles.
- Undefined: no PARITY state, no parity register; behaviour as above.

Test Plan (WIDTH=8, LSB_FIRST=0 unless stated):
1. Reset: hold n_rst=0 for 2 cycles with load_valid=1 and load_data=8'hFF -> load_ready=1, serial_valid=0, serial_out=0, busy=0, done=0. After n_rst=1 with load_valid=0 the block remains idle.
2. Single word: load 8'b11011011, shift_en=1 -> serial_out=1,1,0,1,1,0,1,1 on 8 consecutive cycles with serial_valid=1, then done=1 for one cycle, then busy=0. The downstream detector sees the stream 11011011.
3. Back-to-back: present 8'hDB, then 8'h5A held with load_valid=1 -> 16 contiguous valid bits 11011011 01011010. load_ready is high only in the accept cycle and the last-bit cycle. done pulses after bit 8 and after bit 16.
4. Pacing: shift_en pattern 1,0 repeating on 8'hA5 -> serial_out is 0 in shift_en=0 cycles, and the bit stays held (not advanced) until the next shift_en=1 cycle. 8 bits take 16 cycles; done appears after the 16th cycle.
5. Abort: load 8'hFF, pull n_rst=0 after 3 bits -> next cycle serial_valid=0, busy=0, load_ready=1, and done never pulses. The next loaded word 8'h0F streams 0,0,0,0,1,1,1,1. Repeat with LSB_FIRST=1 -> 1,1,1,1,0,0,0,0.
6. SER_PARITY_EN defined: 8'b11011011 -> 9th bit 0; 8'b11010000 -> 9th bit 1. done follows the 9th bit. Back-to-back reload occurs at the parity-bit edge.
